// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial controller slice.
// Holds the FSM state enum, ALU opcodes and register-file allocation.
package fact_pkg;

    localparam int FACT_W     = 32;
    localparam int FACT_MAX_N = 12;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_N   = 3'd1,
        LOAD_ACC = 3'd2,
        TEST     = 3'd3,
        MUL      = 3'd4,
        DEC      = 3'd5,
        CAPTURE  = 3'd6
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;

    // R0 holds the down-counter k, R1 the running product.
    localparam logic [1:0] REG_K   = 2'd0;
    localparam logic [1:0] REG_ACC = 2'd1;

endpackage

// File: rtl/fact_ctrl_decode.sv
// Combinational state -> datapath control table for factorial_ctrl.
// Ports: rst, state, n_q (captured operand) in; all dp_* controls out.
module fact_ctrl_decode
    import fact_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         rst,
    input  logic [2:0]   state,
    input  logic [W-1:0] n_q,
    output logic         dp_wd_sele,
    output logic         dp_write_en,
    output logic         dp_read_imm,
    output logic [1:0]   dp_read_add1,
    output logic [1:0]   dp_read_add2,
    output logic [1:0]   dp_write_add,
    output logic [2:0]   dp_operation,
    output logic [W-1:0] dp_imm
);

    state_t st;
    assign st = state_t'(state);

    always_comb begin
        dp_wd_sele   = 1'b0;
        dp_write_en  = 1'b0;
        dp_read_imm  = 1'b0;
        dp_read_add1 = 2'd0;
        dp_read_add2 = 2'd0;
        dp_write_add = 2'd0;
        dp_operation = OP_ADD;
        dp_imm       = '0;
        // Reset forces every control low even before the state
        // register has been cleared, so no write slips through.
        if (!rst) begin
            unique case (st)
                LOAD_N: begin
                    dp_wd_sele   = 1'b1;
                    dp_imm       = n_q;
                    dp_write_add = REG_K;
                    dp_write_en  = 1'b1;
                end
                LOAD_ACC: begin
                    dp_wd_sele   = 1'b1;
                    dp_imm       = W'(1);
                    dp_write_add = REG_ACC;
                    dp_write_en  = 1'b1;
                end
                TEST: begin
                    dp_read_add1 = REG_K;
                    dp_read_imm  = 1'b1;
                    dp_operation = OP_SUB;
                end
                MUL: begin
                    dp_read_add1 = REG_ACC;
                    dp_read_add2 = REG_K;
                    dp_operation = OP_MUL;
                    dp_write_add = REG_ACC;
                    dp_write_en  = 1'b1;
                end
                DEC: begin
                    dp_read_add1 = REG_K;
                    dp_read_imm  = 1'b1;
                    dp_imm       = W'(1);
                    dp_operation = OP_SUB;
                    dp_write_add = REG_K;
                    dp_write_en  = 1'b1;
                end
                CAPTURE: begin
                    dp_read_add1 = REG_ACC;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/factorial_ctrl.sv
// Moore FSM sequencing a register-file + ALU datapath to compute n!.
// Host side: clk, rst, start, n_in in; busy, done, fact_out out.
// Datapath side: dp_* controls out; dp_is_zero, dp_result in.
// Optional macro FACT_OVF_EN adds the ovf port and the n > MAX_N
// early-out (done one clock later, fact_out all ones, ovf set).
module factorial_ctrl
    import fact_pkg::*;
#(
    parameter int W     = 32,
    parameter int MAX_N = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] n_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] fact_out,
`ifdef FACT_OVF_EN
    output logic         ovf,
`endif
    output logic         dp_wd_sele,
    output logic         dp_write_en,
    output logic         dp_read_imm,
    output logic [1:0]   dp_read_add1,
    output logic [1:0]   dp_read_add2,
    output logic [1:0]   dp_write_add,
    output logic [2:0]   dp_operation,
    output logic [W-1:0] dp_imm,
    input  logic         dp_is_zero,
    input  logic [W-1:0] dp_result
);

    state_t       state;
    state_t       state_d;
    logic [W-1:0] n_q;
    logic         accept;
    logic         ovf_req;

    assign accept = (state == IDLE) && start;

`ifdef FACT_OVF_EN
    assign ovf_req = accept && (n_in > W'(MAX_N));
`else
    assign ovf_req = 1'b0;
`endif

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:     if (accept && !ovf_req) state_d = LOAD_N;
            LOAD_N:   state_d = LOAD_ACC;
            LOAD_ACC: state_d = TEST;
            TEST:     state_d = dp_is_zero ? CAPTURE : MUL;
            MUL:      state_d = DEC;
            DEC:      state_d = TEST;
            CAPTURE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fact_out <= '0;
`ifdef FACT_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept && !ovf_req) begin
                n_q  <= n_in;
                busy <= 1'b1;
            end
            if (state == CAPTURE) begin
                fact_out <= dp_result;
                done     <= 1'b1;
                busy     <= 1'b0;
`ifdef FACT_OVF_EN
                ovf      <= 1'b0;
`endif
            end
`ifdef FACT_OVF_EN
            // Out-of-range n never touches the datapath.
            if (ovf_req) begin
                fact_out <= '1;
                done     <= 1'b1;
                ovf      <= 1'b1;
            end
`endif
        end
    end

    fact_ctrl_decode #(.W(W)) u_decode (
        .rst          (rst),
        .state        (state),
        .n_q          (n_q),
        .dp_wd_sele   (dp_wd_sele),
        .dp_write_en  (dp_write_en),
        .dp_read_imm  (dp_read_imm),
        .dp_read_add1 (dp_read_add1),
        .dp_read_add2 (dp_read_add2),
        .dp_write_add (dp_write_add),
        .dp_operation (dp_operation),
        .dp_imm       (dp_imm)
    );

endmodule
